ftq_meta_buffer: RTL and testbench
==================================

Name: ftq_meta_buffer

Overview:
- Fetch target queue that stores per-fetch-block prediction metadata (PC, bank, pattern, folded history) for the back end.
- The PC-generation stage allocates entries and stamps the returned FTQ id (8-bit, MSB valid) into its bundle.
- The back end reads metadata back by that id on redirect and branch-predictor update.
- Commit releases entries in order. Redirect truncates younger entries.

Parameters:
DEPTH, 16, number of entries; power of two, 2..128
DW, 256, width of the stored metadata payload in bits
IW, $clog2(DEPTH), index width

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
flush  input  1  discard all entries
alloc_valid  input  1  PC stage requests an entry
alloc_ready  output  1  entry available
alloc_data  input  DW  metadata written on allocation
alloc_id  output  8  id granted on fire; {1'b1, 0-padded index}
rd_id  input  8  read request id, MSB valid
rd_data  output  DW  read payload, registered
rd_hit  output  1  rd_data valid and the id was live
red_valid  input  1  redirect from back end
red_id  input  8  id of the redirecting entry (kept; younger entries dropped)
com_valid  input  1  commit release
com_id  input  8  release all entries up to and including this id
count  output  IW+1  live entry count
err  output  1  sticky flag: redirect or commit to a non-live id

Behaviour:
- Storage: DEPTH x DW register array, not reset.
- Pointers: head and tail, each IW+1 bits with a wrap bit.
  - count = tail - head, modulo 2^(IW+1).
  - Empty when count == 0; full when count == DEPTH.
- Reset: head = tail = 0, rd_data = 0, rd_hit = 0, err = 0, count = 0, alloc_ready = 1.
- Liveness: index i is live when ((i - head[IW-1:0]) mod DEPTH) < count, using registered state.
- Allocation:
  - alloc_ready = !full && !red_valid && !flush, from registered count only; a same-cycle commit does not open space.
  - alloc_id = {1, tail index zero-extended to 7 bits}, combinational.
  - Fire = alloc_valid && alloc_ready: write alloc_data at the tail index; tail += 1.
- Read:
  - Latency is one cycle.
  - Cycle N samples rd_id. Cycle N+1 presents rd_data = array[rd_id index] and rd_hit = rd_id[7] && live(index).
  - Liveness is taken from cycle-N state, so an entry allocated in cycle N is not a hit.
  - When rd_hit = 0, rd_data holds its previous value.
- Redirect:
  - Accepted only if red_id[7] && live(red_id index).
  - On accept: tail = head + ((red_idx - head_idx) mod DEPTH) + 1; younger entries are discarded.
  - On non-live id: ignored and err is set.
- Commit:
  - Accepted only if com_id[7] && live(com_id index).
  - On accept: head = head + ((com_idx - head_idx) mod DEPTH) + 1.
  - On non-live id: ignored and err is set.
- Same-cycle priority:
  - flush beats everything: head = tail = 0 on the next edge; alloc, commit and redirect are dropped. err is not cleared.
  - Redirect and commit together are both applied; both offsets use the pre-edge head. If the commit offset exceeds the redirect offset, the result is empty and err is set.
  - Commit and alloc together are both applied.
  - Redirect and alloc together: alloc is blocked (alloc_ready = 0).
- Wrap-around: indices wrap modulo DEPTH. The pointer wrap bit distinguishes full from empty.
- Reset mid-operation (asynchronous) returns all state to reset values immediately. Bundles in flight carrying ids become non-live.
- err clears only on rst.

Test Plan:
- DEPTH=4: allocate 4 entries with payloads 0xA0..0xA3 -> alloc_id 0x80, 0x81, 0x82, 0x83; count = 4; alloc_ready = 0. A 5th alloc_valid holds with no fire.
- Read rd_id = 0x82 after the fill -> next cycle rd_data = 0xA2, rd_hit = 1. Read rd_id = 0x02 (MSB clear) -> rd_hit = 0.
- Full, commit com_id = 0x81 -> count = 2 next cycle, head index 2. Allocate 0xB0 -> alloc_id 0x80 (wrap); read 0x80 -> 0xB0, hit.
- 4 live entries at indices 2, 3, 0, 1; redirect red_id = 0x83 -> count = 2; read 0x80 -> rd_hit = 0; next alloc_id = 0x80.
- Same cycle: red_valid (0x83), com_valid (0x82), alloc_valid -> alloc not fired; head index 3, count = 1.
- Commit com_id = 0x83 when empty -> ignored, err = 1. flush with 3 live entries -> count = 0, err unchanged. rst -> err = 0.

Source files
------------

// File: rtl/ftq_meta_buffer.sv
// Fetch target queue metadata store: in-order alloc/commit ring with id-based
// read-back, redirect truncation and a sticky error flag for stale ids.
module ftq_meta_buffer #(
    parameter int DEPTH = 16,
    parameter int DW    = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          alloc_valid,
    output logic          alloc_ready,
    input  logic [DW-1:0] alloc_data,
    output logic [7:0]    alloc_id,
    input  logic [7:0]    rd_id,
    output logic [DW-1:0] rd_data,
    output logic          rd_hit,
    input  logic          red_valid,
    input  logic [7:0]    red_id,
    input  logic          com_valid,
    input  logic [7:0]    com_id,
    output logic [IW:0]   count,
    output logic          err
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [IW:0]   head_q, head_d, tail_q, tail_d;
    logic          err_q, err_d;
    logic [DW-1:0] rd_data_q;
    logic          rd_hit_q;

    logic [IW-1:0] rd_idx, red_idx, com_idx, red_off, com_off;
    logic          full, fire, rd_live, red_ok, com_ok;
    logic [IW:0]   red_tail, com_head;
    logic          unused_id_bits;

    // Offset from head modulo DEPTH; live when it falls inside the occupied span.
    function automatic logic live(input logic [IW-1:0] idx);
        logic [IW-1:0] off;
        off = idx - head_q[IW-1:0];
        return ({1'b0, off} < count);
    endfunction

    assign count   = tail_q - head_q;
    assign full    = (count == (IW+1)'(DEPTH));
    assign rd_idx  = rd_id[IW-1:0];
    assign red_idx = red_id[IW-1:0];
    assign com_idx = com_id[IW-1:0];
    assign red_off = red_idx - head_q[IW-1:0];
    assign com_off = com_idx - head_q[IW-1:0];

    assign rd_live = rd_id[7] && live(rd_idx);
    assign red_ok  = red_valid && red_id[7] && live(red_idx);
    assign com_ok  = com_valid && com_id[7] && live(com_idx);

    assign red_tail = head_q + (IW+1)'(red_off) + (IW+1)'(1);
    assign com_head = head_q + (IW+1)'(com_off) + (IW+1)'(1);

    // Space freed by a same-cycle commit is deliberately not visible here.
    assign alloc_ready = !full && !red_valid && !flush;
    assign fire        = alloc_valid && alloc_ready;

    always_comb begin
        alloc_id            = '0;
        alloc_id[IW-1:0]    = tail_q[IW-1:0];
        alloc_id[7]         = 1'b1;
    end

    assign unused_id_bits = ^{rd_id, red_id, com_id};

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        err_d  = err_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (fire)
                tail_d = tail_q + (IW+1)'(1);
            if (red_valid) begin
                if (red_ok) tail_d = red_tail;
                else        err_d  = 1'b1;
            end
            if (com_valid) begin
                if (com_ok) head_d = com_head;
                else        err_d  = 1'b1;
            end
            // Commit past the redirect point: nothing survives.
            if (red_ok && com_ok && (com_off > red_off)) begin
                head_d = red_tail;
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            err_q     <= 1'b0;
            rd_hit_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            err_q    <= err_d;
            rd_hit_q <= rd_live;
            if (rd_live)
                rd_data_q <= mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (fire)
            mem_q[tail_q[IW-1:0]] <= alloc_data;
    end

    assign rd_data = rd_data_q;
    assign rd_hit  = rd_hit_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ftq_meta_buffer.sv
// Directed bench for ftq_meta_buffer at DEPTH=4, DW=8.
module tb_ftq_meta_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int IW    = 2;

    logic          clk = 1'b0;
    logic          rst, flush, alloc_valid, alloc_ready;
    logic [DW-1:0] alloc_data, rd_data;
    logic [7:0]    alloc_id, rd_id, red_id, com_id;
    logic          rd_hit, red_valid, com_valid, err;
    logic [IW:0]   count;

    int n_cmp = 0;
    int n_bad = 0;

    ftq_meta_buffer #(.DEPTH(DEPTH), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_data(alloc_data), .alloc_id(alloc_id),
        .rd_id(rd_id), .rd_data(rd_data), .rd_hit(rd_hit),
        .red_valid(red_valid), .red_id(red_id),
        .com_valid(com_valid), .com_id(com_id),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; alloc_valid = 0; alloc_data = '0; rd_id = '0;
        red_valid = 0; red_id = '0; com_valid = 0; com_id = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        cyc(); cyc();
        rst = 0;
        #1;
        n_cmp++; if (count !== 3'd0)     begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (alloc_ready !== 1)  begin n_bad++; $display("FAIL reset_ready got %b exp 1", alloc_ready); end
        n_cmp++; if (err !== 0)          begin n_bad++; $display("FAIL reset_err got %b exp 0", err); end
        n_cmp++; if (rd_hit !== 0 || rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd got %b/%h exp 0/00", rd_hit, rd_data); end
        n_cmp++; if (alloc_id !== 8'h80) begin n_bad++; $display("FAIL reset_id got %h exp 80", alloc_id); end
    endtask

    task automatic test_fill();
        logic [7:0] exp_id;
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1; alloc_data = 8'hA0 + 8'(i);
            exp_id = 8'h80 + 8'(i);
            #1;
            n_cmp++; if (alloc_id !== exp_id || alloc_ready !== 1) begin n_bad++; $display("FAIL fill_id[%0d] got %h/%b exp %h/1", i, alloc_id, alloc_ready, exp_id); end
            cyc();
        end
        alloc_valid = 1; alloc_data = 8'hEE;
        #1;
        n_cmp++; if (count !== 3'd4 || alloc_ready !== 0) begin n_bad++; $display("FAIL full got count %0d ready %b exp 4/0", count, alloc_ready); end
        cyc();
        alloc_valid = 0;
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_hold got %0d exp 4", count); end
    endtask

    task automatic test_read();
        rd_id = 8'h82; cyc();
        n_cmp++; if (rd_hit !== 1 || rd_data !== 8'hA2) begin n_bad++; $display("FAIL rd_82 got %b/%h exp 1/a2", rd_hit, rd_data); end
        rd_id = 8'h02; cyc();
        n_cmp++; if (rd_hit !== 0 || rd_data !== 8'hA2) begin n_bad++; $display("FAIL rd_msb0 got %b/%h exp 0/a2", rd_hit, rd_data); end
        rd_id = 8'h00;
    endtask

    task automatic test_commit_wrap();
        com_valid = 1; com_id = 8'h81; cyc();
        com_valid = 0;
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL commit_count got %0d exp 2", count); end
        rd_id = 8'h81; cyc();
        n_cmp++; if (rd_hit !== 0) begin n_bad++; $display("FAIL commit_released got %b exp 0", rd_hit); end
        rd_id = 8'h00;
        alloc_valid = 1; alloc_data = 8'hB0; #1;
        n_cmp++; if (alloc_id !== 8'h80) begin n_bad++; $display("FAIL wrap_id got %h exp 80", alloc_id); end
        cyc();
        alloc_data = 8'hC1; cyc();
        alloc_valid = 0;
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL wrap_count got %0d exp 4", count); end
        rd_id = 8'h80; cyc();
        n_cmp++; if (rd_hit !== 1 || rd_data !== 8'hB0) begin n_bad++; $display("FAIL rd_wrap got %b/%h exp 1/b0", rd_hit, rd_data); end
        rd_id = 8'h00;
    endtask

    task automatic test_redirect();
        red_valid = 1; red_id = 8'h83; cyc();
        red_valid = 0;
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL red_count got %0d exp 2", count); end
        rd_id = 8'h80; cyc();
        n_cmp++; if (rd_hit !== 0) begin n_bad++; $display("FAIL red_dropped got %b exp 0", rd_hit); end
        rd_id = 8'h00;
        n_cmp++; if (alloc_id !== 8'h80) begin n_bad++; $display("FAIL red_next_id got %h exp 80", alloc_id); end
    endtask

    task automatic test_same_cycle();
        red_valid = 1; red_id = 8'h83; com_valid = 1; com_id = 8'h82;
        alloc_valid = 1; alloc_data = 8'h55; #1;
        n_cmp++; if (alloc_ready !== 0) begin n_bad++; $display("FAIL sc_ready got %b exp 0", alloc_ready); end
        cyc();
        idle();
        n_cmp++; if (count !== 3'd1 || err !== 0) begin n_bad++; $display("FAIL sc_count got %0d/%b exp 1/0", count, err); end
        rd_id = 8'h83; cyc();
        n_cmp++; if (rd_hit !== 1 || rd_data !== 8'hA3) begin n_bad++; $display("FAIL sc_rd83 got %b/%h exp 1/a3", rd_hit, rd_data); end
        rd_id = 8'h82; cyc();
        n_cmp++; if (rd_hit !== 0) begin n_bad++; $display("FAIL sc_rd82 got %b exp 0", rd_hit); end
        rd_id = 8'h00;
    endtask

    task automatic test_conflict();
        alloc_valid = 1; alloc_data = 8'hE0; cyc();
        alloc_data = 8'hE1; cyc();
        alloc_valid = 0;
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL cf_fill got %0d exp 3", count); end
        red_valid = 1; red_id = 8'h83; com_valid = 1; com_id = 8'h80; cyc();
        idle();
        n_cmp++; if (count !== 3'd0 || err !== 1) begin n_bad++; $display("FAIL cf_empty got %0d/%b exp 0/1", count, err); end
    endtask

    task automatic test_async_reset();
        alloc_valid = 1; alloc_data = 8'hF0; cyc();
        alloc_valid = 0;
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL ar_pre got %0d exp 1", count); end
        #2 rst = 1;
        #1;
        n_cmp++; if (count !== 3'd0 || err !== 0 || alloc_id !== 8'h80) begin n_bad++; $display("FAIL ar_now got %0d/%b/%h exp 0/0/80", count, err, alloc_id); end
        cyc();
        rst = 0;
    endtask

    task automatic test_err_flush();
        com_valid = 1; com_id = 8'h83; cyc();
        com_valid = 0;
        n_cmp++; if (err !== 1 || count !== 3'd0) begin n_bad++; $display("FAIL err_empty got %b/%0d exp 1/0", err, count); end
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1; alloc_data = 8'hD0 + 8'(i); cyc();
        end
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL fl_fill got %0d exp 3", count); end
        flush = 1; #1;
        n_cmp++; if (alloc_ready !== 0) begin n_bad++; $display("FAIL fl_ready got %b exp 0", alloc_ready); end
        cyc();
        idle();
        n_cmp++; if (count !== 3'd0 || err !== 1 || alloc_id !== 8'h80) begin n_bad++; $display("FAIL flush got %0d/%b/%h exp 0/1/80", count, err, alloc_id); end
        rst = 1; #1;
        n_cmp++; if (err !== 0) begin n_bad++; $display("FAIL rst_err got %b exp 0", err); end
        cyc();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_fill();
        test_read();
        test_commit_wrap();
        test_redirect();
        test_same_cycle();
        test_conflict();
        test_async_reset();
        test_err_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
